// File: rtl/comm_pkg.sv
// comm_pkg: shared types and constants for the copter comm master.
//   frm_state_t : frame FSM states (3-byte command frame)
//   rx_state_t  : UART receiver states
//   FRAME_BYTES : bytes per command frame (cmd, data_hi, data_lo)
package comm_pkg;

  localparam int unsigned FRAME_BYTES = 3;
  // Start bit + 8 data bits + stop bit.
  localparam int unsigned UART_BITS   = 10;
  localparam int unsigned BIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BYTE_HI  = 2'd1,
    BYTE_MID = 2'd2,
    BYTE_LO  = 2'd3
  } frm_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/comm_master_uart_tx.sv
// uart_tx: 8N1 byte serializer, BAUD_DIV clocks per bit (BAUD_DIV >= 2).
//   clk, rst_n : clock, async active-low reset
//   tx_data    : byte to send, sampled when trmt is accepted
//   trmt       : start request; accepted when idle or in the last stop-bit cycle
//   TX         : registered serial output, idle high
//   tx_done    : registered pulse high during the final cycle of the stop bit,
//                so a caller can chain the next byte with no idle gap
module uart_tx
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic                 busy;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [8:0]           shft;
  logic                 bit_end_c;
  logic                 last_c;
  logic                 load_c;

  assign bit_end_c = busy && (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign last_c    = bit_end_c && (bit_cnt == BIT_CNT_W'(UART_BITS - 1));
  assign load_c    = trmt && (!busy || last_c);

  // Serializer: TX drives the start bit on load, then shifts data and stop bit out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shft     <= '1;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= busy && (bit_cnt == BIT_CNT_W'(UART_BITS - 1)) &&
                 (baud_cnt == CNT_W'(BAUD_DIV - 2));
      if (load_c) begin
        busy     <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shft     <= {1'b1, tx_data};
        TX       <= 1'b0;
      end else if (last_c) begin
        busy     <= 1'b0;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        TX       <= 1'b1;
      end else if (bit_end_c) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        TX       <= shft[0];
        shft     <= {1'b1, shft[8:1]};
      end else if (busy) begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/comm_master.sv
// comm_master: sends 3-byte command frames (cmd, data[15:8], data[7:0]) over
// UART TX and receives single response bytes on RX, full duplex.
//   clk, rst_n          : clock, async active-low reset
//   cmd, data, snd_cmd  : frame contents and one-cycle send request
//   TX, frm_snt         : serial out; high once the whole frame is out
//   RX                  : asynchronous serial in
//   resp, resp_rdy      : last received byte and its ready flag
//   clr_resp_rdy        : knocks down resp_rdy
// Build option: define COMM_MASTER_FRAME_ERR_EN to discard received bytes
// whose stop-bit sample is 0.
module comm_master
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        frm_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned HALF  = BAUD_DIV / 2;

  // ---------------- transmit frame ----------------
  frm_state_t  state_q, state_nxt;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        trmt_c;
  logic [7:0]  tx_byte_c;
  logic        tx_done;
  logic        accept_c;

  assign accept_c = (state_q == IDLE) && snd_cmd;

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_byte_c),
    .trmt    (trmt_c),
    .TX      (TX),
    .tx_done (tx_done)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state and byte hand-off; the first byte comes straight from cmd so the
  // start bit begins the cycle after the request.
  always_comb begin
    state_nxt = state_q;
    trmt_c    = 1'b0;
    tx_byte_c = cmd_q;
    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          state_nxt = BYTE_HI;
          trmt_c    = 1'b1;
          tx_byte_c = cmd;
        end
      end
      BYTE_HI: begin
        if (tx_done) begin
          state_nxt = BYTE_MID;
          trmt_c    = 1'b1;
          tx_byte_c = data_q[15:8];
        end
      end
      BYTE_MID: begin
        if (tx_done) begin
          state_nxt = BYTE_LO;
          trmt_c    = 1'b1;
          tx_byte_c = data_q[7:0];
        end
      end
      BYTE_LO: begin
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding registers and frame-sent flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      data_q  <= '0;
      frm_snt <= 1'b0;
    end else begin
      if (accept_c) begin
        cmd_q   <= cmd;
        data_q  <= data;
        frm_snt <= 1'b0;
      end else if ((state_q == BYTE_LO) && tx_done) begin
        frm_snt <= 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state_q, rx_state_nxt;
  logic                 rx_ff1, rx_s, rx_prev;
  logic [CNT_W-1:0]     rx_baud;
  logic [BIT_CNT_W-1:0] rx_bit;
  logic [7:0]           rx_shft;
  logic                 start_c, samp_c, abort_c, stop_c, byte_ok_c;

  assign start_c = (rx_state_q == RX_IDLE) && rx_prev && !rx_s;
  assign samp_c  = (rx_state_q == RX_RECV) && (rx_baud == CNT_W'(HALF - 1));
  assign abort_c = samp_c && (rx_bit == '0) && rx_s;
  assign stop_c  = samp_c && (rx_bit == BIT_CNT_W'(UART_BITS - 1));

`ifdef COMM_MASTER_FRAME_ERR_EN
  assign byte_ok_c = stop_c && rx_s;
`else
  assign byte_ok_c = stop_c;
`endif

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_q <= RX_IDLE;
    else        rx_state_q <= rx_state_nxt;
  end

  // Receiver next state: a false start or the stop sample returns to idle.
  always_comb begin
    rx_state_nxt = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (start_c) rx_state_nxt = RX_RECV;
      RX_RECV: if (abort_c || stop_c) rx_state_nxt = RX_IDLE;
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Synchronizer, bit timing, shift register and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shft  <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      rx_ff1  <= RX;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
      if (start_c) begin
        rx_baud <= '0;
        rx_bit  <= '0;
      end else if (rx_state_q == RX_RECV) begin
        rx_baud <= (rx_baud == CNT_W'(BAUD_DIV - 1)) ? '0 : rx_baud + CNT_W'(1);
        if (samp_c) rx_bit <= rx_bit + BIT_CNT_W'(1);
      end
      // Only data-bit samples enter the shifter (LSB arrives first).
      if (samp_c && (rx_bit != '0) && !stop_c) rx_shft <= {rx_s, rx_shft[7:1]};
      if (byte_ok_c) resp <= rx_shft;
      // Set has priority over either clear source.
      if (byte_ok_c)                    resp_rdy <= 1'b1;
      else if (clr_resp_rdy || start_c) resp_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// tb_comm_master: directed, table-driven bench for comm_master at BAUD_DIV=16.
module tb_comm_master;

  localparam int unsigned BAUD  = 16;
  localparam int unsigned BYTE_T = 10 * BAUD;
  localparam int unsigned FRM_T  = 3 * BYTE_T;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        TX;
  logic        RX = 1'b1;
  logic        frm_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  comm_master #(.BAUD_DIV(BAUD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd),
    .data         (data),
    .snd_cmd      (snd_cmd),
    .TX           (TX),
    .RX           (RX),
    .frm_snt      (frm_snt),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    bit          chg;   // change cmd/data right after acceptance
    bit          mid;   // extra snd_cmd pulse in the middle of the frame
    logic [7:0]  e0, e1, e2;
  } tx_vec_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [7:0] e_resp;
    logic       e_rdy;
  } rx_vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request a frame and check every bit of the serial stream at mid-bit.
  task automatic run_frame(input tx_vec_t v, input string tag);
    logic [9:0] fr [3];
    int         lows;
    @(negedge clk);
    cmd = v.cmd; data = v.data; snd_cmd = 1'b1;
    for (int t = 0; t <= int'(FRM_T); t++) begin
      @(negedge clk);
      if (t == 0) begin
        check($sformatf("%s start_bit", tag), 16'(TX), 16'h0);
        check($sformatf("%s frm_snt_clr", tag), 16'(frm_snt), 16'h0);
      end
      if ((t < int'(FRM_T)) && ((t % int'(BAUD)) == int'(BAUD / 2)))
        fr[t / int'(BYTE_T)][(t % int'(BYTE_T)) / int'(BAUD)] = TX;
      if (t == int'(FRM_T) - 1) check($sformatf("%s frm_snt_early", tag), 16'(frm_snt), 16'h0);
      if (t == int'(FRM_T))     check($sformatf("%s frm_snt_set", tag), 16'(frm_snt), 16'h1);
      if (t == 0) begin
        snd_cmd = 1'b0;
        if (v.chg) begin cmd = 8'hFF; data = 16'h0000; end
      end
      if (v.mid && t == 200) begin snd_cmd = 1'b1; cmd = 8'h77; data = 16'h1234; end
      if (v.mid && t == 201) snd_cmd = 1'b0;
    end
    check($sformatf("%s byte0", tag), 16'(fr[0]), 16'({1'b1, v.e0, 1'b0}));
    check($sformatf("%s byte1", tag), 16'(fr[1]), 16'({1'b1, v.e1, 1'b0}));
    check($sformatf("%s byte2", tag), 16'(fr[2]), 16'({1'b1, v.e2, 1'b0}));
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (TX == 1'b0) lows++;
    end
    check($sformatf("%s tx_idle_after", tag), 16'(lows), 16'h0);
    check($sformatf("%s frm_snt_hold", tag), 16'(frm_snt), 16'h1);
  endtask

  // Drive one 8N1 byte on RX with a chosen stop-bit level.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] w;
    w = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX = w[i];
      repeat (BAUD - 1) @(negedge clk);
    end
    @(negedge clk);
    RX = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  tx_vec_t tv [4];
  rx_vec_t rv [4];

  initial begin
    int lows;
    int highs;
    tv[0] = '{8'h05, 16'hA55A, 1'b0, 1'b0, 8'h05, 8'hA5, 8'h5A};
    tv[1] = '{8'h05, 16'hA55A, 1'b1, 1'b0, 8'h05, 8'hA5, 8'h5A};
    tv[2] = '{8'h3C, 16'h0F81, 1'b0, 1'b1, 8'h3C, 8'h0F, 8'h81};
    tv[3] = '{8'h00, 16'hFFFF, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF};
    rv[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    rv[1] = '{8'h00, 1'b1, 8'h00, 1'b1};
    rv[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
`ifdef COMM_MASTER_FRAME_ERR_EN
    rv[3] = '{8'h3C, 1'b0, 8'hFF, 1'b0};
`else
    rv[3] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
`endif

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst TX", 16'(TX), 16'h1);
    check("rst frm_snt", 16'(frm_snt), 16'h0);
    check("rst resp", 16'(resp), 16'h0);
    check("rst resp_rdy", 16'(resp_rdy), 16'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) run_frame(tv[i], $sformatf("tx%0d", i));

    // Receive table; each byte followed by a clr_resp_rdy pulse.
    for (int i = 0; i < 4; i++) begin
      send_rx(rv[i].b, rv[i].stop);
      check($sformatf("rx%0d resp", i), 16'(resp), 16'(rv[i].e_resp));
      check($sformatf("rx%0d resp_rdy", i), 16'(resp_rdy), 16'(rv[i].e_rdy));
      @(negedge clk); clr_resp_rdy = 1'b1;
      @(negedge clk); clr_resp_rdy = 1'b0;
      @(negedge clk);
      check($sformatf("rx%0d clr_rdy", i), 16'(resp_rdy), 16'h0);
      check($sformatf("rx%0d clr_resp", i), 16'(resp), 16'(rv[i].e_resp));
    end

    // One-cycle RX glitch must not produce a byte.
    @(negedge clk); RX = 1'b0;
    @(negedge clk); RX = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch resp_rdy", 16'(resp_rdy), 16'h0);
    check("glitch resp", 16'(resp), 16'(rv[3].e_resp));

    // Full duplex: frame out while a byte comes in.
    fork
      run_frame('{8'h12, 16'h3456, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56}, "duplex");
      send_rx(8'h5A, 1'b1);
    join
    check("duplex resp", 16'(resp), 16'h005A);
    check("duplex resp_rdy", 16'(resp_rdy), 16'h1);

    // Reset at clock 200 of a frame (bit 1 of byte A5, which is 0).
    @(negedge clk); cmd = 8'h05; data = 16'hA55A; snd_cmd = 1'b1;
    @(negedge clk); snd_cmd = 1'b0;
    repeat (199) @(negedge clk);
    check("midrst tx_before", 16'(TX), 16'h0);
    rst_n = 1'b0;
    #1;
    check("midrst TX", 16'(TX), 16'h1);
    check("midrst frm_snt", 16'(frm_snt), 16'h0);
    check("midrst resp", 16'(resp), 16'h0);
    check("midrst resp_rdy", 16'(resp_rdy), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    lows = 0; highs = 0;
    repeat (600) begin
      @(negedge clk);
      if (TX == 1'b0) lows++;
      if (frm_snt == 1'b1) highs++;
    end
    check("midrst tx_stays_idle", 16'(lows), 16'h0);
    check("midrst no_frm_snt", 16'(highs), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
